uart_rx_fifo: RTL and testbench

- UART receiver (8N1, LSB first) with a receive FIFO. It is the host-to-CPU counterpart of the existing UART transmit path.
- The CPU polls and pops received bytes through the MMIO decoder at 0xF000_0104, using COUNT/VALID and DATA. This path carries from_host console input and runtime data after program load.
- Runs in the CPU clock domain. RXD is asynchronous and is synchronized internally.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_byte_fifo.sv | 75 +++++++
 rtl/uart_rx_fifo.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state type, the
// default bit period in CPU clocks, and serial frame constants.
// The transmitter uses the same DEFAULT_SERIAL_WCNT so both directions
// agree on the baud rate.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Receiver FSM states. The RX_ prefix keeps these names distinct from
    // the DATA output port of the receiver top level.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // CPU clocks per serial bit (CPU_FREQ / BAUDRATE).
    localparam int DEFAULT_SERIAL_WCNT = 120;

    // 8N1 framing: eight data bits, LSB first, one stop bit at line level 1.
    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_byte_fifo
// First-word-fall-through byte FIFO of depth 2^FIFO_LOG for received bytes.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (pointers only)
//   push   in   store din this cycle (accepted when not full, or when full
//               and a pop happens in the same cycle)
//   pop    in   drop the head entry; ignored while empty
//   din    in   byte to store
//   dout   out  head byte, forced to 0 while empty
//   count  out  number of stored bytes (0 .. 2^FIFO_LOG)
//   full   out  count equals 2^FIFO_LOG
//   valid  out  FIFO non-empty
// ---------------------------------------------------------------------------
module uart_rx_byte_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic [FIFO_LOG:0]    count,
    output logic                 full,
    output logic                 valid
);

    localparam int DEPTH = 1 << FIFO_LOG;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [FIFO_LOG:0]    wr_ptr;
    logic [FIFO_LOG:0]    rd_ptr;
    logic                 pop_ok;
    logic                 push_ok;

    // Pointers carry one extra bit so that full and empty are distinct
    // while both wrap naturally.
    assign count = wr_ptr - rd_ptr;
    assign valid = (count != '0);
    // count never exceeds DEPTH, so its MSB is set exactly when full.
    assign full  = count[FIFO_LOG];

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset; the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_LOG-1:0]] <= din;
        end
    end

    assign dout = valid ? mem[rd_ptr[FIFO_LOG-1:0]] : '0;

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver (LSB first) feeding a receive FIFO that the CPU polls
// and pops through MMIO. Runs in the CPU clock domain; RXD is synchronized
// internally.
//
// Ports:
//   CLK        in   CPU clock, rising edge
//   RST_X      in   asynchronous active-low reset
//   RXD        in   serial input, idle high
//   RE         in   pop the head entry (honoured only while VALID=1)
//   CLR        in   synchronous clear of the sticky error flags
//   DATA       out  head byte, first-word-fall-through, 0 while VALID=0
//   VALID      out  FIFO non-empty
//   COUNT      out  number of stored bytes
//   FULL       out  COUNT equals 2^FIFO_LOG
//   OVERFLOW   out  sticky: a complete byte was dropped on a full FIFO
//   FRAME_ERR  out  sticky: a stop bit was sampled as 0
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int SERIAL_WCNT = DEFAULT_SERIAL_WCNT,
    parameter int FIFO_LOG    = 4
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 RXD,
    input  logic                 RE,
    input  logic                 CLR,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 VALID,
    output logic [FIFO_LOG:0]    COUNT,
    output logic                 FULL,
    output logic                 OVERFLOW,
    output logic                 FRAME_ERR
);

    // SERIAL_WCNT-1 always fits in clog2(SERIAL_WCNT) bits.
    localparam int CNT_W = $clog2(SERIAL_WCNT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(SERIAL_WCNT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(SERIAL_WCNT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic                 rxd_meta;
    logic                 rxd_s;
    logic                 rxd_d;
    logic                 fall;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;

    logic                 push;
    logic                 frame_set;
    logic                 drop;
    logic                 overflow_q;
    logic                 frame_err_q;

    // Two-flop synchronizer plus one delay flop for edge detection. All
    // reset to the idle level so releasing reset never looks like a start.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_d    <= 1'b1;
        end else begin
            rxd_meta <= RXD;
            rxd_s    <= rxd_meta;
            rxd_d    <= rxd_s;
        end
    end

    // Only a 1-to-0 transition starts a frame, so a line stuck low (for
    // example after a framing error) never retriggers.
    assign fall = rxd_d & ~rxd_s;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // The cycle counter is loaded with (period - 1) and sampling happens
    // on the cycle it reads zero. The start bit is checked half a period
    // after the edge, so every later sample lands mid-bit. The FSM leaves
    // STOP at the stop-bit midpoint, leaving half a bit of slack to catch
    // the next start edge of back-to-back frames.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_LOAD;
                    state_d = RX_START;
                end
            end

            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_s) begin
                        cnt_d   = BIT_LOAD;
                        bit_d   = '0;
                        state_d = RX_DATA;
                    end else begin
                        // Line went back high before mid start bit: glitch.
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d[bit_q] = rxd_s;
                    cnt_d          = BIT_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (cnt_q == '0) begin
                    state_d = RX_IDLE;
                    if (rxd_s == STOP_LEVEL) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    uart_rx_byte_fifo #(
        .FIFO_LOG (FIFO_LOG)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_X),
        .push  (push),
        .pop   (RE),
        .din   (shift_q),
        .dout  (DATA),
        .count (COUNT),
        .full  (FULL),
        .valid (VALID)
    );

    // A byte is lost only if the FIFO is full and no pop frees a slot in
    // the same cycle.
    assign drop = push & FULL & ~(RE & VALID);

    // Sticky flags: a set event in the same cycle as CLR wins.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (CLR) begin
                overflow_q <= 1'b0;
            end
            if (frame_set) begin
                frame_err_q <= 1'b1;
            end else if (CLR) begin
                frame_err_q <= 1'b0;
            end
        end
    end

    assign OVERFLOW  = overflow_q;
    assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed and randomized serial frames against a queue-based model of the
// receive FIFO and its sticky flags.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int W     = 8;
    localparam int FL    = 4;
    localparam int DEPTH = 1 << FL;
    // Edge index (counted from the edge after which the start bit is
    // driven) at which the stop bit begins, and after which VALID must show
    // the new byte: 2 synchronizer edges, half a bit to the start sample,
    // nine bit times to the stop sample, one edge to write the FIFO.
    localparam int STOP_EDGE = 9 * W;
    localparam int PUSH_EDGE = 2 + W / 2 + 9 * W + 1;

    logic          CLK = 1'b0;
    logic          RST_X;
    logic          RXD;
    logic          RE;
    logic          CLR;
    logic [7:0]    DATA;
    logic          VALID;
    logic [FL:0]   COUNT;
    logic          FULL;
    logic          OVERFLOW;
    logic          FRAME_ERR;

    int            checkCount = 0;
    int            passCount  = 0;
    int            failCount  = 0;

    logic [7:0]    expQ[$];
    logic          expOvf;
    logic          expFerr;

    uart_rx_fifo #(
        .SERIAL_WCNT (W),
        .FIFO_LOG    (FL)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .RXD       (RXD),
        .RE        (RE),
        .CLR       (CLR),
        .DATA      (DATA),
        .VALID     (VALID),
        .COUNT     (COUNT),
        .FULL      (FULL),
        .OVERFLOW  (OVERFLOW),
        .FRAME_ERR (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        assert (obs === expv) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] head;
        head = (expQ.size() > 0) ? expQ[0] : 8'h00;
        check({tag, ".valid"},    32'(VALID),     32'(expQ.size() != 0));
        check({tag, ".count"},    32'(COUNT),     32'(expQ.size()));
        check({tag, ".full"},     32'(FULL),      32'(expQ.size() == DEPTH));
        check({tag, ".data"},     32'(DATA),      32'(head));
        check({tag, ".overflow"}, 32'(OVERFLOW),  32'(expOvf));
        check({tag, ".frameerr"}, 32'(FRAME_ERR), 32'(expFerr));
    endtask

    // All stimulus is applied 1 time unit after a rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        RXD = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one serial frame and updates the model. popAtPush holds RE
    // high during the cycle in which the byte is pushed; checkRise checks
    // VALID every cycle of the stop bit against the expected push edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stopLvl,
                                 input bit popAtPush, input bit checkRise);
        bit wasValid;
        wasValid = (expQ.size() != 0);
        RXD = 1'b0;
        repeat (W) tick();
        for (int k = 0; k < 8; k++) begin
            RXD = b[k];
            repeat (W) tick();
        end
        RXD = stopLvl;
        for (int i = 1; i <= W; i++) begin
            @(posedge CLK);
            #1;
            if (popAtPush) RE = (STOP_EDGE + i == PUSH_EDGE - 1);
            if (checkRise)
                check($sformatf("rise@%0d", STOP_EDGE + i), 32'(VALID),
                      32'(wasValid || (STOP_EDGE + i >= PUSH_EDGE)));
        end
        RE = 1'b0;
        if (stopLvl) begin
            if (popAtPush && expQ.size() > 0) void'(expQ.pop_front());
            if (expQ.size() < DEPTH) expQ.push_back(b);
            else expOvf = 1'b1;
        end else begin
            expFerr = 1'b1;
        end
    endtask

    task automatic popByte();
        RE = 1'b1;
        tick();
        RE = 1'b0;
        if (expQ.size() > 0) void'(expQ.pop_front());
    endtask

    task automatic popCheck(input string tag, input logic [7:0] expv);
        check(tag, 32'(DATA), 32'(expv));
        popByte();
    endtask

    task automatic clrFlags();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        expOvf  = 1'b0;
        expFerr = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        logic       rs;
        int         np;

        RST_X = 1'b0;
        RXD = 1'b1;
        RE = 1'b0;
        CLR = 1'b0;
        expOvf = 1'b0;
        expFerr = 1'b0;
        #3;
        checkOutput("reset");
        tick();
        tick();
        RST_X = 1'b1;
        idle(4);
        checkOutput("idle");

        $display("[TB] single frame latency");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        checkOutput("a5");
        check("a5.const", 32'(DATA), 32'h0000_00A5);
        popByte();
        checkOutput("a5.pop");

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 1'b0);
        checkOutput("b2b");
        check("b2b.count3", 32'(COUNT), 32'd3);
        popCheck("b2b.pop0", 8'h00);
        popCheck("b2b.pop1", 8'hFF);
        popCheck("b2b.pop2", 8'h3C);
        checkOutput("b2b.empty");

        $display("[TB] start glitch");
        RXD = 1'b0;
        tick();
        tick();
        idle(3 * W);
        checkOutput("glitch");
        applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
        checkOutput("glitch.5a");
        popCheck("glitch.pop", 8'h5A);

        $display("[TB] framing error");
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b0);
        idle(W);
        checkOutput("ferr");
        check("ferr.flag", 32'(FRAME_ERR), 32'd1);
        clrFlags();
        checkOutput("ferr.clr");

        $display("[TB] overflow");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("ovf.f%0d", i));
        end
        check("ovf.full", 32'(FULL), 32'd1);
        check("ovf.flag", 32'(OVERFLOW), 32'd1);
        for (int i = 0; i < 16; i++) popCheck($sformatf("ovf.pop%0d", i), 8'(i));
        checkOutput("ovf.drained");
        clrFlags();
        checkOutput("ovf.clr");

        $display("[TB] full with pop on push cycle");
        for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b1, 1'b0);
        checkOutput("fullpop");
        check("fullpop.ovf", 32'(OVERFLOW), 32'd0);
        for (int i = 1; i <= 16; i++) popCheck($sformatf("fullpop.pop%0d", i), 8'(i));
        checkOutput("fullpop.drained");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
        RXD = 1'b0;
        repeat (W) tick();
        for (int k = 0; k < 3; k++) begin
            RXD = 1'b1;
            repeat (W) tick();
        end
        RXD = 1'b0;
        repeat (W / 2) tick();
        RST_X = 1'b0;
        #1;
        expQ.delete();
        expOvf = 1'b0;
        expFerr = 1'b0;
        checkOutput("rst.mid");
        tick();
        RXD = 1'b1;
        tick();
        RST_X = 1'b1;
        idle(2 * W);
        checkOutput("rst.after");
        applyStimulus(8'h12, 1'b1, 1'b0, 1'b0);
        checkOutput("rst.12");
        popCheck("rst.pop", 8'h12);
        checkOutput("rst.empty");

        $display("[TB] randomized frames");
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 5) != 0);
            applyStimulus(rb, rs, 1'b0, 1'b0);
            if (!rs) idle(W);
            np = $urandom_range(0, 2);
            for (int p = 0; p < np; p++) popByte();
            if ($urandom_range(0, 3) == 0) clrFlags();
            checkOutput($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
